round_sequencer: RTL and testbench

Top-level round controller for the pattern-memory game. It takes over the sequencing that is currently spread across ad-hoc delay counters in the game manager:
- latches the selected level;
- waits for the start key;
- clears and enables pattern generation, pattern display and input capture in order, once per round;
- judges each round and counts rounds and correct answers;
- produces the final score for the 7-segment printer.

It sits between level selection and the generator/print/input-trim datapath.

---
 rtl/round_sequencer.sv | 91 +++++++++
 tb/tb_round_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// round_sequencer: round controller for the pattern game (level latch, per-round clear/gen/print/input sequencing, judging, final score)
module round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int GAP_CYCLES = 2,
  parameter int POINTS = 10
) (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        level_select_end,
  input  logic [2:0]  level,
  input  logic        start,
  input  logic        pattern_gen_end,
  input  logic        print_pattern_end,
  input  logic        input_trim_end,
  input  logic        round_win,
  output logic        sub_clr,
  output logic        pattern_gen_en,
  output logic        print_en,
  output logic        input_en,
  output logic [15:0] lv_enable,
  output logic [4:0]  round_count,
  output logic [3:0]  answer_count,
  output logic        game_end,
  output logic [6:0]  score
);
  localparam logic [4:0] LAST = 5'(NUM_ROUNDS);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [6:0] PTS = 7'(POINTS);
  typedef enum logic [3:0] {IDLE, ARM, CLR, GEN, PRINT, INPUT, JUDGE, GAP, DONE} state_t;
  state_t r_state, w_next;
  logic [2:0] r_level;
  logic       r_win;
  logic [3:0] r_gap;
  logic       w_level_ok;
  logic [4:0] w_round;
  logic [3:0] w_answer;
  always_comb begin
    w_level_ok = level == 3'b001 || level == 3'b010 || level == 3'b100;
    w_round = round_count + 5'd1;
    w_answer = answer_count + {3'b000, r_win};
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = level_select_end && w_level_ok ? ARM : IDLE;
      ARM:     w_next = start ? CLR : ARM;
      CLR:     w_next = GEN;
      GEN:     w_next = pattern_gen_end ? PRINT : GEN;
      PRINT:   w_next = print_pattern_end ? INPUT : PRINT;
      INPUT:   w_next = input_trim_end ? JUDGE : INPUT;
      JUDGE:   w_next = w_round == LAST ? DONE : GAP;
      GAP:     w_next = r_gap == GAP_LAST ? CLR : GAP;
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_1) begin
    if (rst) begin
      r_state <= IDLE;
      r_level <= 3'd0;
      r_win <= 1'b0;
      r_gap <= 4'd0;
      sub_clr <= 1'b0;
      pattern_gen_en <= 1'b0;
      print_en <= 1'b0;
      input_en <= 1'b0;
      lv_enable <= 16'd0;
      round_count <= 5'd0;
      answer_count <= 4'd0;
      game_end <= 1'b0;
      score <= 7'd0;
    end else begin
      r_state <= w_next;
      sub_clr <= w_next == CLR;
      pattern_gen_en <= w_next == GEN;
      print_en <= w_next == PRINT;
      input_en <= w_next == INPUT;
      r_gap <= r_state == GAP && w_next == GAP ? r_gap + 4'd1 : 4'd0;
      if (r_state == IDLE && w_next == ARM) r_level <= level;
      if (r_state == ARM && w_next == CLR)
        lv_enable <= r_level[2] ? 16'hFFFF : r_level[1] ? 16'h0FFF : r_level[0] ? 16'h00FF : 16'h0000;
      if (r_state == INPUT && input_trim_end) r_win <= round_win;
      if (r_state == JUDGE) begin
        round_count <= w_round;
        answer_count <= w_answer;
      end
      if (r_state == JUDGE && w_next == DONE) begin
        game_end <= 1'b1;
        score <= PTS * {3'b000, w_answer};
      end
    end
  end
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: table vectors, directed corner sequences and randomized games against a round-level model
module tb_round_sequencer;
  localparam int NR = 10;
  localparam int GAP = 2;
  localparam int PTS = 10;
  logic clk_1 = 1'b0, rst = 1'b0, level_select_end = 1'b0, start = 1'b0;
  logic [2:0] level = 3'd0;
  logic pattern_gen_end = 1'b0, print_pattern_end = 1'b0, input_trim_end = 1'b0, round_win = 1'b0;
  logic sub_clr, pattern_gen_en, print_en, input_en, game_end;
  logic [15:0] lv_enable;
  logic [4:0] round_count;
  logic [3:0] answer_count;
  logic [6:0] score;
  int checks = 0, errors = 0, clr_pulses = 0, overlaps = 0;
  typedef struct { logic [2:0] lvl; logic exp_clr; logic [15:0] exp_lv; } vec_t;
  vec_t vecs[8];
  round_sequencer #(.NUM_ROUNDS(NR), .GAP_CYCLES(GAP), .POINTS(PTS)) dut (
    .clk_1(clk_1), .rst(rst), .level_select_end(level_select_end), .level(level), .start(start),
    .pattern_gen_end(pattern_gen_end), .print_pattern_end(print_pattern_end),
    .input_trim_end(input_trim_end), .round_win(round_win), .sub_clr(sub_clr),
    .pattern_gen_en(pattern_gen_en), .print_en(print_en), .input_en(input_en),
    .lv_enable(lv_enable), .round_count(round_count), .answer_count(answer_count),
    .game_end(game_end), .score(score)
  );
  always #5 clk_1 = ~clk_1;
  always @(negedge clk_1) if (!rst) begin
    clr_pulses += int'(sub_clr);
    if (int'(pattern_gen_en) + int'(print_en) + int'(input_en) > 1) overlaps++;
  end
  function automatic logic [15:0] lv_of(input logic [2:0] l);
    int slots;
    slots = l == 3'b001 ? 8 : l == 3'b010 ? 12 : l == 3'b100 ? 16 : 0;
    return 16'((32'd1 << slots) - 1);
  endfunction
  task automatic tick();
    @(posedge clk_1);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_en"}, {sub_clr, pattern_gen_en, print_en, input_en, game_end}, 5'd0);
    chk({n, "_lv"}, lv_enable, 16'd0);
    chk({n, "_cnt"}, {round_count, answer_count, score}, 16'd0);
  endtask
  task automatic noise(input int keep, input bit nz, input bit hold);
    pattern_gen_end = nz && keep != 0 && $urandom_range(0, 3) == 0;
    print_pattern_end = nz && keep != 1 && $urandom_range(0, 3) == 0;
    input_trim_end = nz && keep != 2 && $urandom_range(0, 3) == 0;
    round_win = 1'($urandom);
    start = hold || (nz && $urandom_range(0, 2) == 0);
  endtask
  task automatic do_reset();
    {level_select_end, start, pattern_gen_end, print_pattern_end, input_trim_end, round_win} = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("reset");
  endtask
  task automatic run_game(input logic [2:0] lvl, input logic [15:0] wins, input bit nz, input bit hold, input int abort_at);
    int base_clr, base_ov, acc, gap;
    do_reset();
    base_clr = clr_pulses;
    base_ov = overlaps;
    acc = 0;
    level = lvl;
    level_select_end = 1'b1;
    tick();
    level_select_end = 1'b0;
    if (nz) level = 3'($urandom);
    repeat ($urandom_range(0, 2)) tick();
    chk("arm_wait", sub_clr, 0);
    start = 1'b1;
    tick();
    chk("first_clr", sub_clr, 1);
    chk("lv_enable", lv_enable, lv_of(lvl));
    for (int r = 0; r < NR; r++) begin
      noise(3, nz, hold);
      tick();
      chk("gen_en", {sub_clr, pattern_gen_en}, 2'b01);
      if (r == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("rst_midgen");
        return;
      end
      repeat ($urandom_range(0, 3)) begin
        noise(0, nz, hold);
        tick();
        chk("gen_hold", {pattern_gen_en, print_en, input_en}, 3'b100);
      end
      noise(0, nz, hold);
      pattern_gen_end = 1'b1;
      tick();
      chk("print_en", {pattern_gen_en, print_en, input_en}, 3'b010);
      repeat ($urandom_range(0, 3)) begin
        noise(1, nz, hold);
        tick();
        chk("print_hold", {pattern_gen_en, print_en, input_en}, 3'b010);
      end
      noise(1, nz, hold);
      print_pattern_end = 1'b1;
      tick();
      chk("input_en", {pattern_gen_en, print_en, input_en}, 3'b001);
      repeat ($urandom_range(0, 3)) begin
        noise(2, nz, hold);
        tick();
        chk("input_hold", {input_en, round_count}, {1'b1, 5'(r)});
      end
      noise(2, nz, hold);
      input_trim_end = 1'b1;
      round_win = wins[r];
      tick();
      noise(3, nz, hold);
      chk("judge_pre", {input_en, round_count}, {1'b0, 5'(r)});
      tick();
      acc += int'(wins[r]);
      chk("round_count", round_count, r + 1);
      chk("answer_count", answer_count, acc);
      if (r < NR - 1) begin
        chk("game_end_early", game_end, 0);
        gap = 0;
        while (!sub_clr && gap < 40) begin
          noise(3, nz, hold);
          tick();
          gap++;
        end
        chk("gap_len", gap, GAP);
      end
    end
    chk("game_end", game_end, 1);
    chk("score", score, PTS * acc);
    repeat (4) begin
      noise(3, 1, 1);
      tick();
      chk("done_hold", {game_end, sub_clr, pattern_gen_en, score, round_count}, {2'b10, 1'b0, 7'(PTS * acc), 5'(NR)});
    end
    chk("clr_pulses", clr_pulses - base_clr, NR);
    chk("overlap", overlaps - base_ov, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{3'b001, 1'b1, 16'h00FF};
    vecs[1] = '{3'b010, 1'b1, 16'h0FFF};
    vecs[2] = '{3'b100, 1'b1, 16'hFFFF};
    vecs[3] = '{3'b000, 1'b0, 16'h0000};
    vecs[4] = '{3'b011, 1'b0, 16'h0000};
    vecs[5] = '{3'b101, 1'b0, 16'h0000};
    vecs[6] = '{3'b110, 1'b0, 16'h0000};
    vecs[7] = '{3'b111, 1'b0, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      level = vecs[i].lvl;
      level_select_end = 1'b1;
      tick();
      level_select_end = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("vec_clr", sub_clr, vecs[i].exp_clr);
      chk("vec_lv", lv_enable, vecs[i].exp_lv);
    end
    do_reset();
    level = 3'b011;
    level_select_end = 1'b1;
    tick();
    level_select_end = 1'b0;
    start = 1'b1;
    tick();
    chk("bad_level_idle", {sub_clr, lv_enable}, 17'd0);
    start = 1'b0;
    level = 3'b100;
    level_select_end = 1'b1;
    tick();
    level_select_end = 1'b0;
    level = 3'b010;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("retry_clr", sub_clr, 1);
    chk("retry_lv", lv_enable, 16'hFFFF);
    run_game(3'b010, 16'h03FF, 1'b0, 1'b0, -1);
    run_game(3'b001, 16'h0155, 1'b1, 1'b0, -1);
    run_game(3'b100, 16'($urandom), 1'b1, 1'b0, 2);
    for (int g = 0; g < 4; g++) begin
      logic [2:0] l;
      l = 3'b001 << $urandom_range(0, 2);
      run_game(l, 16'($urandom), 1'b1, 1'($urandom), -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
